// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle over WIDTH cycles.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiwriteE,
  input  logic             lowriteE,
  input  logic [WIDTH-1:0] wdataE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, stateNext;

  logic [CW-1:0]    count;
  logic             lastIter;
  logic             isDiv, signsDiffer, remNeg, divZero;
  logic [WIDTH-1:0] rawA, opB, accHi, accLo;

  logic signed [WIDTH-1:0] srcaSigned, srcbSigned;
  logic                    signedOp, aNeg, bNeg;

  logic [WIDTH:0]     mulSum, divShift;
  logic [WIDTH-1:0]   divDiff, stepHi, stepLo;
  logic               divGe;
  logic [2*WIDTH-1:0] product;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic isNeg);
    return isNeg ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] applySignWide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  assign srcaSigned = srcaE;
  assign srcbSigned = srcbE;
  assign signedOp   = ~opE[0];
  assign aNeg       = signedOp & (srcaSigned < 0);
  assign bNeg       = signedOp & (srcbSigned < 0);
  assign lastIter   = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startE) stateNext = RUN;
      RUN:     if (lastIter) stateNext = DONE;
      DONE:    stateNext = startE ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // accHi holds the partial product high half or the running remainder;
  // accLo holds the unconsumed multiplier bits or the quotient being shifted in.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divGe    = (divShift >= {1'b0, opB});
    divDiff  = divShift[WIDTH-1:0] - opB;
    if (isDiv) begin
      stepHi = divGe ? divDiff : divShift[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], divGe};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
    product = applySignWide({stepHi, stepLo}, signsDiffer);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      isDiv       <= 1'b0;
      signsDiffer <= 1'b0;
      remNeg      <= 1'b0;
      divZero     <= 1'b0;
      rawA        <= '0;
      opB         <= '0;
      accHi       <= '0;
      accLo       <= '0;
      hi          <= '0;
      lo          <= '0;
    end else if (state != RUN) begin
      if (hiwriteE) hi <= wdataE;
      if (lowriteE) lo <= wdataE;
      if (startE) begin
        count       <= '0;
        isDiv       <= opE[1];
        signsDiffer <= aNeg ^ bNeg;
        remNeg      <= aNeg;
        divZero     <= (srcbE == '0);
        rawA        <= srcaE;
        accHi       <= '0;
        if (opE[1]) begin
          accLo <= magnitude(srcaSigned, aNeg);
          opB   <= magnitude(srcbSigned, bNeg);
        end else begin
          accLo <= magnitude(srcbSigned, bNeg);
          opB   <= magnitude(srcaSigned, aNeg);
        end
      end
    end else begin
      count <= count + 1'b1;
      accHi <= stepHi;
      accLo <= stepLo;
      if (lastIter) begin
        if (!isDiv) begin
          {hi, lo} <= product;
        end else if (divZero) begin
          hi <= rawA;
          lo <= '1;
        end else begin
          hi <= applySign(stepHi, remNeg);
          lo <= applySign(stepLo, signsDiffer);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model plus directed vectors
// with hand-computed results.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         startE = 1'b0;
  logic [1:0]   opE = 2'd0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         hiwriteE = 1'b0;
  logic         lowriteE = 1'b0;
  logic [W-1:0] wdataE = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .hiwriteE(hiwriteE), .lowriteE(lowriteE),
    .wdataE(wdataE), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Architectural result {hi, lo} of one operation.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  int           mRun = 0;
  logic         mDone = 1'b0;
  logic [W-1:0] mHi = '0, mLo = '0;
  logic [63:0]  pend = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mRun  <= 0;
      mDone <= 1'b0;
      mHi   <= '0;
      mLo   <= '0;
    end else if (mRun > 0) begin
      mRun  <= mRun - 1;
      mDone <= (mRun == 1);
      if (mRun == 1) begin
        mHi <= pend[63:32];
        mLo <= pend[31:0];
      end
    end else begin
      mDone <= 1'b0;
      if (hiwriteE) mHi <= wdataE;
      if (lowriteE) mLo <= wdataE;
      if (startE) begin
        pend <= refResult(opE, srcaE, srcbE);
        mRun <= W;
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if (busy !== (mRun > 0) || done !== mDone || hi !== mHi || lo !== mLo) begin
      bad++;
      $display("FAIL cycle t=%0t busy=%b want %b done=%b want %b hi=%h want %h lo=%h want %h",
               $time, busy, (mRun > 0), done, mDone, hi, mHi, lo, mLo);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for done (bounded); returns edges waited and busy-high samples.
  task automatic waitDone(input string name, output int n, output int busyCnt, output bit ok);
    n = 0;
    busyCnt = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) busyCnt++;
    end
    ok = done;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s timeout got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input bit hiW, input logic [31:0] wd);
    int n, busyCnt;
    bit ok;
    @(posedge clk); #1;
    opE = op; srcaE = a; srcbE = b; startE = 1'b1;
    hiwriteE = hiW; wdataE = wd;
    @(posedge clk); #1;
    startE = 1'b0; hiwriteE = 1'b0;
    opE = 2'($urandom); srcaE = $urandom; srcbE = $urandom;
    if (hiW) chk({name, " mthi with start"}, hi, wd);
    waitDone(name, n, busyCnt, ok);
    if (ok) begin
      chk({name, " latency"}, 32'(n), 32'd32);
      chk({name, " busy cycles"}, 32'(busyCnt), 32'd32);
      chk({name, " hi"}, hi, expHi);
      chk({name, " lo"}, lo, expLo);
    end
  endtask

  initial begin
    int n, busyCnt;
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    #2 reset = 1'b1;

    runOp("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    runOp("mult neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
          1, 32'h0000_1111);
    runOp("mult minsq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 0);
    runOp("div neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    runOp("divu 7/2", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 0, 0);
    runOp("divu by0", 2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0);
    runOp("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0);

    // start and mthi during RUN must be ignored
    @(posedge clk); #1;
    opE = 2'd1; srcaE = 32'd5; srcbE = 32'd6; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    opE = 2'd0; srcaE = 32'd9; srcbE = 32'd9; startE = 1'b1;
    hiwriteE = 1'b1; wdataE = 32'h0000_DEAD;
    @(posedge clk); #1;
    startE = 1'b0; hiwriteE = 1'b0;
    chk("run mthi ignored", hi, 32'h0);
    waitDone("multu 5x6", n, busyCnt, ok);
    if (ok) begin
      chk("multu 5x6 hi", hi, 32'h0);
      chk("multu 5x6 lo", lo, 32'd30);
      lowriteE = 1'b1; wdataE = 32'h0000_BEEF;
      @(posedge clk); #1;
      lowriteE = 1'b0;
      chk("mtlo in done", lo, 32'h0000_BEEF);
      chk("mtlo keeps hi", hi, 32'h0);
    end

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    opE = 2'd2; srcaE = 32'd100; srcbE = 32'd7; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    chk("midrun reset busy", {31'd0, busy}, 32'd0);
    chk("midrun reset done", {31'd0, done}, 32'd0);
    chk("midrun reset hi", hi, 32'h0);
    chk("midrun reset lo", lo, 32'h0);
    #2 reset = 1'b1;

    runOp("multu 3x4", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage; owns the architectural HI/LO registers for mult, multu, div, divu, mthi and mtlo.
- Computes one bit per cycle and raises busy so the hazard unit stalls F/D and flushes E while an operation runs.
- The HI/LO outputs feed the result path of mfhi and mflo.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- startE  in  1  start request, sampled on the rising edge.
- opE  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- srcaE  in  WIDTH  multiplicand or dividend (rs, forwarded).
- srcbE  in  WIDTH  multiplier or divisor (rt, forwarded).
- hiwriteE  in  1  mthi write strobe.
- lowriteE  in  1  mtlo write strobe.
- wdataE  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in progress; the hazard unit ORs it into stallF/stallD/flushE.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Reset (reset==0, any time, including mid-RUN):
  - state goes to IDLE and the iteration counter clears.
  - hi=0, lo=0, busy=0, done=0.
  - internal accumulators clear; any in-flight result is discarded.
- IDLE or DONE with startE=1 at edge T0:
  - latch opE, the operand signs, |srcaE| and |srcbE| (magnitudes only for signed ops; raw values for unsigned ops).
  - clear the counter and go to RUN.
- IDLE or DONE with startE=0: DONE returns to IDLE; IDLE stays.
- RUN: one iteration per edge, counter increments. The edge that completes iteration WIDTH (T32 for WIDTH=32):
  - applies sign correction and writes hi/lo.
  - goes to DONE.
- Latency: start at T0 gives hi/lo valid and done=1 in the cycle after T32, i.e. 33 cycles. busy is high for cycles T0+1 through T32.
- Multiply (shift-add):
  - 2*WIDTH-bit product; {hi,lo} = product.
  - mult negates the product when the operand signs differ.
- Divide (restoring):
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; it is negated when the signs differ. The remainder takes the dividend's sign.
  - Divide by zero: completes with normal latency, no exception. hi = srcaE as latched, lo = all ones.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- startE while in RUN is ignored; there is no restart or queueing.
- hiwriteE/lowriteE:
  - write wdataE into hi/lo at the edge, only outside RUN; ignored during RUN.
  - When a write and startE coincide, both take effect. The result from the start overwrites hi/lo at completion.
- hi/lo hold their value in all other cycles. They change only on reset, at completion, or on an mthi/mtlo write.
- The operand registers are internal. srcaE/srcbE may change after T0 without affecting the result.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF, start at T0 -> busy high for 32 cycles; done one cycle after T32; hi=0xFFFFFFFE, lo=0x00000001.
- mult 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- div 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
- divu 0x00001234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF, 33-cycle latency. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- During RUN of multu 5x6: startE=1 with different operands and hiwriteE=1 with 0xDEAD -> both ignored; final hi=0, lo=30. Then in DONE: lowriteE=1 with 0xBEEF -> lo=0xBEEF next cycle.
- Drive reset low asynchronously at iteration 10 of a divide -> busy, done, hi and lo drop to 0 immediately. Release reset, then a new multu 3x4 -> lo=12 after 33 cycles.
